n8633s_sync_decoder: RTL and testbench



---
 rtl/n8633s_pkg.sv | 31 +++
 rtl/n8633s_win_decode.sv | 45 ++++
 rtl/n8633s_sync_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_n8633s_sync_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/n8633s_pkg.sv
// n8633s_pkg -- shared definitions for the N-8633-S sync decoder.
//   * Legal ranges of the absolute H/V counter buses.
//   * Lock FSM state encoding.
//   * win_hit(): window membership test that wraps when start > end.
package n8633s_pkg;

  localparam logic [8:0] H_MIN = 9'd128;
  localparam logic [8:0] H_MAX = 9'd511;
  localparam logic [8:0] V_MIN = 9'd220;
  localparam logic [8:0] V_MAX = 9'd511;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECKING = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  // A window whose start exceeds its end covers start..max and min..end-1.
  function automatic logic win_hit(input logic [8:0] value,
                                   input logic [8:0] w_start,
                                   input logic [8:0] w_end);
    logic hit;
    if (w_start > w_end) begin
      hit = (value >= w_start) || (value < w_end);
    end else begin
      hit = (value >= w_start) && (value < w_end);
    end
    return hit;
  endfunction

endpackage

// File: rtl/n8633s_win_decode.sv
// n8633s_win_decode -- one 9-bit window comparator with a registered hit.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (hit cleared)
//   en_i     sample enable; the hit register only loads when high
//   value_i  counter value to test
//   hit_o    registered (value in [W_START, W_END)), wrapping when start > end
module n8633s_win_decode
  import n8633s_pkg::*;
#(
  parameter logic [8:0] W_START = 9'd0,
  parameter logic [8:0] W_END   = 9'd0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [8:0] value_i,
  output logic       hit_o
);

  logic hit_q;
  logic hit_d;

  // Next hit value: new decode on enabled edges, otherwise hold.
  always_comb begin
    hit_d = hit_q;
    if (en_i) begin
      hit_d = win_hit(value_i, W_START, W_END);
    end else begin
      hit_d = hit_q;
    end
  end

  // Hit register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/n8633s_sync_decoder.sv
// n8633s_sync_decoder -- decodes the N-8633-S absolute H/V counters into
// sync/blank strobes, checks counter integrity with a lock FSM, and raises
// a VBLANK interrupt with an acknowledge handshake.
// Ports:
//   i_EMU_MCLK          master clock
//   i_EMU_RST           synchronous active-high reset
//   i_EMU_CLK6MPCEN_n   active-low pixel enable; state advances only when low
//   i_ABS_H_CNTR        absolute H counter (128..511)
//   i_ABS_V_CNTR        absolute V counter (220..511)
//   i_IRQ_ACK           acknowledge pulse, honoured on any MCLK edge
//   o_HSYNC_n/o_VSYNC_n active-low syncs (inactive while unlocked)
//   o_CSYNC_n           o_HSYNC_n AND o_VSYNC_n
//   o_HBLANK/o_VBLANK   blanking (forced high while unlocked)
//   o_VBLANK_IRQ_n      active-low interrupt request
//   o_LOCKED            counter stream judged valid
// Optional build macro N8633S_FRAME_COUNTER_EN adds o_FRAME_CNTR[7:0],
// counting interrupt set events.
module n8633s_sync_decoder
  import n8633s_pkg::*;
#(
  parameter logic [8:0] HBLK_START  = 9'd128,
  parameter logic [8:0] HBLK_END    = 9'd256,
  parameter logic [8:0] HSYNC_START = 9'd176,
  parameter logic [8:0] HSYNC_END   = 9'd208,
  parameter logic [8:0] VBLK_START  = 9'd496,
  parameter logic [8:0] VBLK_END    = 9'd272,
  parameter logic [8:0] VSYNC_START = 9'd500,
  parameter logic [8:0] VSYNC_END   = 9'd508,
  parameter int         LOCK_LINES  = 4
) (
  input  logic       i_EMU_MCLK,
  input  logic       i_EMU_RST,
  input  logic       i_EMU_CLK6MPCEN_n,
  input  logic [8:0] i_ABS_H_CNTR,
  input  logic [8:0] i_ABS_V_CNTR,
  input  logic       i_IRQ_ACK,
  output logic       o_HSYNC_n,
  output logic       o_VSYNC_n,
  output logic       o_CSYNC_n,
  output logic       o_HBLANK,
  output logic       o_VBLANK,
  output logic       o_VBLANK_IRQ_n,
  output logic       o_LOCKED
`ifdef N8633S_FRAME_COUNTER_EN
  ,
  output logic [7:0] o_FRAME_CNTR
`endif
);

  localparam int CNT_W = $clog2(LOCK_LINES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_LINES - 1);

  logic pix_en_s;
  assign pix_en_s = ~i_EMU_CLK6MPCEN_n;

  // ---------------- window decodes (1 pixel latency) ----------------
  logic hblk_hit_s, hsync_hit_s, vblk_hit_s, vsync_hit_s;

  n8633s_win_decode #(.W_START(HBLK_START), .W_END(HBLK_END)) u_hblk (
    .clk_i(i_EMU_MCLK), .rst_i(i_EMU_RST), .en_i(pix_en_s),
    .value_i(i_ABS_H_CNTR), .hit_o(hblk_hit_s)
  );
  n8633s_win_decode #(.W_START(HSYNC_START), .W_END(HSYNC_END)) u_hsync (
    .clk_i(i_EMU_MCLK), .rst_i(i_EMU_RST), .en_i(pix_en_s),
    .value_i(i_ABS_H_CNTR), .hit_o(hsync_hit_s)
  );
  n8633s_win_decode #(.W_START(VBLK_START), .W_END(VBLK_END)) u_vblk (
    .clk_i(i_EMU_MCLK), .rst_i(i_EMU_RST), .en_i(pix_en_s),
    .value_i(i_ABS_V_CNTR), .hit_o(vblk_hit_s)
  );
  n8633s_win_decode #(.W_START(VSYNC_START), .W_END(VSYNC_END)) u_vsync (
    .clk_i(i_EMU_MCLK), .rst_i(i_EMU_RST), .en_i(pix_en_s),
    .value_i(i_ABS_V_CNTR), .hit_o(vsync_hit_s)
  );

  // ---------------- integrity check ----------------
  logic [8:0]       h_prev_q, h_prev_d;
  logic [8:0]       v_prev_q, v_prev_d;
  logic [9:0]       h_inc_s, v_inc_s;
  logic             step_good_s, wrap_good_s, sample_good_s;
  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;

  // Increments are one bit wider so 511+1 never aliases to 0.
  assign h_inc_s = {1'b0, h_prev_q} + 10'd1;
  assign v_inc_s = {1'b0, v_prev_q} + 10'd1;

  assign step_good_s = (h_inc_s == {1'b0, i_ABS_H_CNTR}) && (i_ABS_V_CNTR == v_prev_q);
  assign wrap_good_s = (h_prev_q == H_MAX) && (i_ABS_H_CNTR == H_MIN) &&
                       ((v_inc_s == {1'b0, i_ABS_V_CNTR}) ||
                        ((v_prev_q == V_MAX) && (i_ABS_V_CNTR == V_MIN)));
  assign sample_good_s = step_good_s || wrap_good_s;

  // Lock FSM next state and good-line counter.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    h_prev_d   = h_prev_q;
    v_prev_d   = v_prev_q;
    if (pix_en_s) begin
      h_prev_d = i_ABS_H_CNTR;
      v_prev_d = i_ABS_V_CNTR;
      case (state_q)
        // First sample after reset only primes the previous-sample registers.
        ST_UNLOCKED: begin
          state_d    = ST_CHECKING;
          good_cnt_d = CNT_ZERO;
        end
        ST_CHECKING: begin
          if (!sample_good_s) begin
            good_cnt_d = CNT_ZERO;
          end else if (wrap_good_s) begin
            if (good_cnt_q == CNT_LAST) begin
              state_d    = ST_LOCKED;
              good_cnt_d = CNT_ZERO;
            end else begin
              good_cnt_d = good_cnt_q + CNT_ONE;
            end
          end else begin
            good_cnt_d = good_cnt_q;
          end
        end
        ST_LOCKED: begin
          if (!sample_good_s) begin
            state_d    = ST_CHECKING;
            good_cnt_d = CNT_ZERO;
          end else begin
            state_d    = ST_LOCKED;
          end
        end
        default: begin
          state_d    = ST_UNLOCKED;
          good_cnt_d = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // ---------------- VBLANK interrupt ----------------
  logic vblk_dly_q, vblk_dly_d;
  logic irq_n_q, irq_n_d;
  logic irq_set_s;

  // Rising edge of the registered VBLANK decode, seen one enable later.
  assign irq_set_s = pix_en_s && (state_q == ST_LOCKED) && vblk_hit_s && !vblk_dly_q;

  // Interrupt request: set has priority over an acknowledge on the same edge.
  always_comb begin
    vblk_dly_d = pix_en_s ? vblk_hit_s : vblk_dly_q;
    if (irq_set_s) begin
      irq_n_d = 1'b0;
    end else if (i_IRQ_ACK) begin
      irq_n_d = 1'b1;
    end else begin
      irq_n_d = irq_n_q;
    end
  end

  // State registers.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      state_q    <= ST_UNLOCKED;
      good_cnt_q <= CNT_ZERO;
      h_prev_q   <= H_MIN;
      v_prev_q   <= V_MIN;
      vblk_dly_q <= 1'b0;
      irq_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      h_prev_q   <= h_prev_d;
      v_prev_q   <= v_prev_d;
      vblk_dly_q <= vblk_dly_d;
      irq_n_q    <= irq_n_d;
    end
  end

`ifdef N8633S_FRAME_COUNTER_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Frame counter advances on every interrupt set event, wrapping at 255.
  always_comb begin
    if (irq_set_s) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_FRAME_CNTR = frame_cnt_q;
`endif

  // ---------------- outputs (all sourced from registers) ----------------
  logic locked_s, hsync_n_s, vsync_n_s;

  assign locked_s  = (state_q == ST_LOCKED);
  assign hsync_n_s = ~(locked_s & hsync_hit_s);
  assign vsync_n_s = ~(locked_s & vsync_hit_s);

  assign o_HSYNC_n      = hsync_n_s;
  assign o_VSYNC_n      = vsync_n_s;
  assign o_CSYNC_n      = hsync_n_s & vsync_n_s;
  assign o_HBLANK       = ~locked_s | hblk_hit_s;
  assign o_VBLANK       = ~locked_s | vblk_hit_s;
  assign o_VBLANK_IRQ_n = irq_n_q;
  assign o_LOCKED       = locked_s;

endmodule

// File: tb/tb_n8633s_sync_decoder.sv
// Scoreboard bench for n8633s_sync_decoder: the driver pushes the expected
// output vector for each MCLK it drives; a monitor pops and compares it
// 2 time units after the following clock edge.
module tb_n8633s_sync_decoder;

  logic       clk = 1'b0;
  logic       rst, en_n, ack;
  logic [8:0] h, v;
  logic       hs_n, vs_n, cs_n, hb, vb, irq_n, locked;
`ifdef N8633S_FRAME_COUNTER_EN
  logic [7:0] fcnt;
  int         exp_fcnt = 0;
`endif

  always #5 clk = ~clk;

  n8633s_sync_decoder dut (
    .i_EMU_MCLK(clk),
    .i_EMU_RST(rst),
    .i_EMU_CLK6MPCEN_n(en_n),
    .i_ABS_H_CNTR(h),
    .i_ABS_V_CNTR(v),
    .i_IRQ_ACK(ack),
    .o_HSYNC_n(hs_n),
    .o_VSYNC_n(vs_n),
    .o_CSYNC_n(cs_n),
    .o_HBLANK(hb),
    .o_VBLANK(vb),
    .o_VBLANK_IRQ_n(irq_n),
    .o_LOCKED(locked)
`ifdef N8633S_FRAME_COUNTER_EN
    ,
    .o_FRAME_CNTR(fcnt)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_q[$];
  string      tag_q[$];

  // Expected-state variables maintained by the scenario.
  logic       exp_locked, exp_irq_n;
  logic [8:0] lh, lv;       // last counter values sampled on an enabled edge
  logic [8:0] ph, pv;       // last position emitted by step()
  int         clean_wraps;

  // Expected vector {hs_n, vs_n, cs_n, hblank, vblank, irq_n, locked}.
  function automatic logic [6:0] model();
    logic e_hs_n, e_vs_n, e_hb, e_vb;
    e_hb   = !exp_locked || (lh >= 9'd128 && lh < 9'd256);
    e_hs_n = !(exp_locked && lh >= 9'd176 && lh < 9'd208);
    e_vb   = !exp_locked || (lv >= 9'd496) || (lv < 9'd272);
    e_vs_n = !(exp_locked && lv >= 9'd500 && lv < 9'd508);
    return {e_hs_n, e_vs_n, e_hs_n & e_vs_n, e_hb, e_vb, exp_irq_n, exp_locked};
  endfunction

  // Monitor: one comparison per MCLK for which the driver queued a vector.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      logic [6:0] e;
      logic [6:0] a;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {hs_n, vs_n, cs_n, hb, vb, irq_n, locked};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s got {hs,vs,cs,hb,vb,irq,lk}=%b expected %b", t, a, e);
      end
    end
  end

  // Drive one MCLK and queue the expected outputs after its edge.
  task automatic pix(input logic [8:0] hh, input logic [8:0] vv,
                     input logic enn, input logic ak, input logic rr);
    h = hh; v = vv; en_n = enn; ack = ak; rst = rr;
    @(posedge clk);
    if (!rr && !enn) begin
      lh = hh;
      lv = vv;
    end
    exp_q.push_back(model());
    tag_q.push_back($sformatf("h%0d_v%0d_en%0d_ack%0d_rst%0d", hh, vv, !enn, ak, rr));
    #1;
  endtask

  // Advance the clean counter stream by one pixel.
  task automatic step(input logic ak);
    logic [8:0] nh, nv;
    if (ph == 9'd511) begin
      nh = 9'd128;
      nv = (pv == 9'd511) ? 9'd220 : pv + 9'd1;
      clean_wraps++;
    end else begin
      nh = ph + 9'd1;
      nv = pv;
    end
    if (clean_wraps >= 4) exp_locked = 1'b1;
    // VBLANK rose on the (128,496) edge; the request follows one enable later.
    if (nh == 9'd129 && nv == 9'd496 && exp_locked) begin
      exp_irq_n = 1'b0;
`ifdef N8633S_FRAME_COUNTER_EN
      exp_fcnt++;
`endif
    end
    pix(nh, nv, 1'b0, ak, 1'b0);
    ph = nh;
    pv = nv;
  endtask

  // Step the stream until (th,tv) has been emitted; bounded.
  task automatic run_to(input logic [8:0] th, input logic [8:0] tv);
    int n;
    n = 0;
    while (!(ph == th && pv == tv) && n < 20000) begin
      step(1'b0);
      n++;
    end
    checks++;
    if (!(ph == th && pv == tv)) begin
      errors++;
      $display("FAIL run_to got h%0d v%0d expected h%0d v%0d", ph, pv, th, tv);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en_n = 1'b1; ack = 1'b0; h = 9'd128; v = 9'd220;
    exp_locked = 1'b0; exp_irq_n = 1'b1; lh = 9'd0; lv = 9'd0;
    clean_wraps = 0; ph = 9'd128; pv = 9'd220;

    // Reset state, with and without pixel enable.
    pix(9'd128, 9'd220, 1'b1, 1'b0, 1'b1);
    pix(9'd128, 9'd220, 1'b0, 1'b1, 1'b1);

    // Clean stream from H=128/V=220: lock on the 4th wrap (V=224 at H=128).
    pix(9'd128, 9'd220, 1'b0, 1'b0, 1'b0);
    ph = 9'd128; pv = 9'd220; clean_wraps = 0;
    run_to(9'd128, 9'd224);
    // Full locked line: HBLANK 128..255, HSYNC 176..207, CSYNC follows.
    run_to(9'd130, 9'd225);

    // Reset mid-frame.
    exp_locked = 1'b0; exp_irq_n = 1'b1;
    pix(9'd131, 9'd225, 1'b0, 1'b0, 1'b1);

    // Restart near the bottom of the frame; lock at V=494.
    pix(9'd128, 9'd490, 1'b0, 1'b0, 1'b0);
    ph = 9'd128; pv = 9'd490; clean_wraps = 0;
    run_to(9'd128, 9'd496);
    // Ack coincident with the set edge: the request must still assert.
    step(1'b1);

    // Enable held off for 10 MCLKs mid-line; counters deliberately garbage.
    run_to(9'd180, 9'd497);
    repeat (10) pix(9'd300, 9'd300, 1'b1, 1'b0, 1'b0);

    // Through VSYNC (500..507) and the 511->220 wrap, which stays locked.
    run_to(9'd300, 9'd221);

    // H jump 300->305: lock lost on that edge, pending IRQ survives.
    exp_locked = 1'b0; clean_wraps = 0;
    pix(9'd305, 9'd221, 1'b0, 1'b0, 1'b0);
    ph = 9'd305; pv = 9'd221;
    repeat (3) step(1'b0);

    // Acknowledge without pixel enable clears the request on that MCLK.
    exp_irq_n = 1'b1;
    pix(ph, pv, 1'b1, 1'b1, 1'b0);
    pix(ph, pv, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef N8633S_FRAME_COUNTER_EN
    checks++;
    if (fcnt !== exp_fcnt[7:0]) begin
      errors++;
      $display("FAIL frame_cntr got %0d expected %0d", fcnt, exp_fcnt[7:0]);
    end
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
